// File: rtl/vector_slice_streamer.sv
// vector_slice_streamer: walks a vector register's read_index and streams its scalars,
// index 0 first, as a valid/ready stream with one registered output stage.
module vector_slice_streamer #(
  parameter int SCALAR_BITS = 32,
  parameter int LENGTH = 5,
  localparam int INDEX_WIDTH = $clog2(LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [INDEX_WIDTH-1:0] read_index,
  input  logic [SCALAR_BITS-1:0] slice_in,
  output logic [SCALAR_BITS-1:0] out_data,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_rd_idx;
  logic [INDEX_WIDTH-1:0] r_out_index;
  logic [SCALAR_BITS-1:0] r_out_data;
  logic                   r_out_last;
  logic                   r_out_valid;
  logic                   r_done;
  logic                   w_fetch;
  logic                   w_rd_last;
  assign w_fetch    = (r_state == STREAM) && (!r_out_valid || out_ready);
  assign w_rd_last  = r_rd_idx == INDEX_WIDTH'(LENGTH - 1);
  assign busy       = r_state != IDLE;
  assign done       = r_done;
  assign read_index = r_rd_idx;
  assign out_data   = r_out_data;
  assign out_index  = r_out_index;
  assign out_last   = r_out_last;
  assign out_valid  = r_out_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_idx    <= '0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state     <= IDLE;
        r_rd_idx    <= '0;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_rd_idx <= '0;
            r_state  <= STREAM;
          end
          STREAM: if (w_fetch) begin
            r_out_data  <= slice_in;
            r_out_index <= r_rd_idx;
            r_out_last  <= w_rd_last;
            r_out_valid <= 1'b1;
            if (w_rd_last) r_state <= DRAIN;
            else r_rd_idx <= r_rd_idx + 1'b1;
          end
          DRAIN: if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vector_slice_streamer.sv
// tb_vector_slice_streamer: scoreboard bench; expected beats are queued as each vector is
// started and checked by a monitor as handshakes occur.
module tb_vector_slice_streamer;
  localparam int SB = 32;
  localparam int LEN = 5;
  localparam int IW = $clog2(LEN);
  logic clk = 1'b0;
  logic rst_n, start, abort, out_ready;
  logic busy, done, out_last, out_valid;
  logic [IW-1:0] read_index, out_index;
  logic [SB-1:0] slice_in, out_data;
  logic [SB-1:0] vreg [LEN];
  logic [SB+IW:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int hs = 0;

  always #5 clk = ~clk;
  assign slice_in = vreg[read_index];

  vector_slice_streamer #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .read_index(read_index), .slice_in(slice_in), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always @(negedge clk) begin
    if (rst_n && !abort && out_valid && out_ready) begin
      hs++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h idx=%0d last=%0b, expected no beat", out_data, out_index, out_last);
      end else begin
        logic [SB+IW:0] exp;
        exp = sb_q.pop_front();
        if ({out_data, out_index, out_last} !== exp) begin
          errors++;
          $display("FAIL beat: got data=%h idx=%0d last=%0b, expected data=%h idx=%0d last=%0b",
                   out_data, out_index, out_last, exp[SB+IW:IW+1], exp[IW:1], exp[0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vreg();
    for (int i = 0; i < LEN; i++) vreg[i] = SB'(i * 'h11);
  endtask

  task automatic push_vec();
    for (int i = 0; i < LEN; i++) sb_q.push_back({vreg[i], IW'(i), i == LEN - 1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int dcnt, output int first);
    dcnt = 0;
    first = 0;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (done) begin
        dcnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b valid=%b last=%b, expected all 0", busy, done, out_valid, out_last);
    end
    checks++;
    if (read_index !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL reset_index: got read_index=%0d out_index=%0d, expected 0", read_index, out_index);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", out_data);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int dcnt, first;
    load_vreg();
    out_ready = 1'b1;
    push_vec();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || read_index !== '0) begin
      errors++;
      $display("FAIL basic_e0: got busy=%b valid=%b read_index=%0d, expected 1 0 0", busy, out_valid, read_index);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL basic_first_beat: got valid=%b idx=%0d data=%h, expected 1 0 00000000", out_valid, out_index, out_data);
    end
    run_to_done(8, dcnt, first);
    checks++;
    if (dcnt !== 1 || first !== 5) begin
      errors++;
      $display("FAIL basic_done: got count=%0d at cycle=%0d, expected 1 at 5", dcnt, first);
    end
    checks++;
    if (sb_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got left=%0d busy=%b, expected 0 0", sb_q.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    int dcnt, first, hs0;
    load_vreg();
    out_ready = 1'b1;
    hs0 = hs;
    push_vec();
    pulse_start();
    cyc();
    cyc();
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h22 || out_index !== 2 || read_index !== 3) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h idx=%0d rd=%0d, expected 1 00000022 2 3",
                 k, out_valid, out_data, out_index, read_index);
      end
      cyc();
    end
    out_ready = 1'b1;
    run_to_done(10, dcnt, first);
    checks++;
    if (hs - hs0 !== 5 || dcnt !== 1 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_total: got handshakes=%0d done=%0d left=%0d, expected 5 1 0", hs - hs0, dcnt, sb_q.size());
    end
  endtask

  task automatic test_late_write();
    int dcnt, first;
    load_vreg();
    out_ready = 1'b1;
    sb_q.push_back({32'h00, IW'(0), 1'b0});
    sb_q.push_back({32'h11, IW'(1), 1'b0});
    sb_q.push_back({32'h22, IW'(2), 1'b0});
    sb_q.push_back({32'hAA, IW'(3), 1'b0});
    sb_q.push_back({32'h44, IW'(4), 1'b1});
    pulse_start();
    cyc();
    cyc();
    checks++;
    if (out_index !== 1) begin
      errors++;
      $display("FAIL late_pos: got idx=%0d, expected 1", out_index);
    end
    vreg[3] = 32'hAA;
    vreg[0] = 32'hBB;
    run_to_done(8, dcnt, first);
    checks++;
    if (dcnt !== 1 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL late_done: got done=%0d left=%0d, expected 1 0", dcnt, sb_q.size());
    end
  endtask

  task automatic test_abort();
    int dcnt, first;
    load_vreg();
    out_ready = 1'b1;
    sb_q.push_back({32'h00, IW'(0), 1'b0});
    sb_q.push_back({32'h11, IW'(1), 1'b0});
    pulse_start();
    cyc();
    cyc();
    cyc();
    out_ready = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0 || read_index !== '0) begin
      errors++;
      $display("FAIL abort_state: got valid=%b busy=%b done=%b last=%b rd=%0d, expected all 0",
               out_valid, busy, done, out_last, read_index);
    end
    run_to_done(4, dcnt, first);
    checks++;
    if (dcnt !== 0 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_nodone: got done=%0d left=%0d, expected 0 0", dcnt, sb_q.size());
    end
    out_ready = 1'b1;
    push_vec();
    pulse_start();
    run_to_done(10, dcnt, first);
    checks++;
    if (dcnt !== 1 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_restart: got done=%0d left=%0d, expected 1 0", dcnt, sb_q.size());
    end
  endtask

  task automatic test_ignored_start();
    int dcnt, first;
    load_vreg();
    out_ready = 1'b1;
    push_vec();
    pulse_start();
    cyc();
    cyc();
    pulse_start();
    run_to_done(10, dcnt, first);
    checks++;
    if (dcnt !== 1 || sb_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: got done=%0d left=%0d busy=%b, expected 1 0 0", dcnt, sb_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt, first;
    load_vreg();
    out_ready = 1'b1;
    push_vec();
    pulse_start();
    for (int i = 0; i < 20 && !done; i++) cyc();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got done=%b busy=%b, expected 1 0", done, busy);
    end
    vreg[2] = 32'h5A;
    push_vec();
    pulse_start();
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b idx=%0d, expected 1 0", out_valid, out_index);
    end
    run_to_done(8, dcnt, first);
    checks++;
    if (dcnt !== 1 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_done: got done=%0d left=%0d, expected 1 0", dcnt, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    load_vreg();
    out_ready = 1'b0;
    pulse_start();
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0 || read_index !== '0 || out_index !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b valid=%b last=%b rd=%0d idx=%0d data=%h, expected all 0",
               busy, done, out_valid, out_last, read_index, out_index, out_data);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    load_vreg();
    test_reset();
    test_basic();
    test_backpressure();
    test_late_write();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending beats, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
